lsu_align_ctrl: RTL and testbench
=================================

// Module: lsu_align_ctrl
// PURPOSE
//  Sequential load/store unit between the MEM stage and data memory.
//  Takes one access per handshake and drives a req/ack memory bus that tolerates wait states.
//  Aligns and byte-enables stores, and extracts and extends loads.
//  Optionally splits accesses that cross a bus word into two bus beats; otherwise flags AdEL/AdES.
// PARAMETERS
//  DATA_W          32  bus width in bits (32 or 64); NB = DATA_W/8 byte lanes
//  ADDR_W          32  byte-address width
//  ALLOW_UNALIGNED 1   1: split boundary-crossing accesses into 2 beats; 0: raise address exception
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  req_valid  in   1       access request
//  req_ready  out  1       high only in IDLE
//  req_op     in   3       000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data in the low-order bits
//  resp_valid out  1       one-cycle completion pulse
//  resp_rdata out  32      extended load data; 0 for stores and exceptions
//  resp_exc   out  2       00 none, 01 AdEL, 10 AdES
//  bus_req    out  1       bus beat request
//  bus_we     out  1       write beat
//  bus_addr   out  ADDR_W  NB-aligned beat address
//  bus_be     out  NB      byte-lane enables (write only; 0 on reads)
//  bus_wdata  out  DATA_W  lane-aligned store data
//  bus_ack    in   1       beat complete; bus_rdata valid in the same cycle
//  bus_rdata  in   DATA_W  read data
// BEHAVIOUR
//  Reset and outputs
//  - Reset (clk edge with reset=1) forces state IDLE and clears all registered outputs and captured data.
//  - While reset=1, req_valid and bus_ack are ignored.
//  - In the first cycle after reset falls, req_ready=1 and all other outputs are 0.
//  State machine: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE
//  - Accept on req_valid&&req_ready: capture op, addr, wdata; size S = 4/2/1 bytes for W/H/B.
//    Offset o = addr mod NB; cross = (o+S > NB); natural misalignment = addr mod S != 0.
//  - ALLOW_UNALIGNED=0 and misaligned: IDLE->RESP directly, no bus beat; resp_exc = 01 for loads, 10 for stores.
//  - ALLOW_UNALIGNED=1: no exception ever raised; misaligned accesses with cross=0 use one beat.
//  - BEAT0: bus_req=1; bus_addr = addr with low log2(NB) bits cleared.
//    All bus_* outputs are held stable until the cycle bus_ack=1.
//    On ack: go to BEAT1 if cross, else RESP.
//  - BEAT1: bus_addr = BEAT0 address + NB, modulo 2^ADDR_W (wraps to 0).
//    Carries the remaining S-(NB-o) bytes in lanes starting at 0. On ack: go to RESP.
//  - Store lanes: byte i of the store goes to lane o+i in BEAT0.
//    Overflow bytes go to lane i-(NB-o) in BEAT1; bus_be is set only on written lanes; other wdata lanes are 0.
//  - Load: bytes are gathered from bus_rdata in the ack cycle(s), low byte first.
//    LH/LB sign-extend to 32 bits; LHU/LBU zero-extend; LW takes the value as-is.
//  - bus_req drops in the cycle after the final ack; at most one request is in flight.
//  - RESP: resp_valid=1 for exactly one cycle with rdata/exc; next cycle IDLE and req_ready=1.
//  Latency and boundary cases
//  - Latency with ack in the first bus cycle: accept at T, BEAT0 at T+1, resp_valid at T+2.
//    A split access responds at T+3. Each wait cycle adds 1.
//  - bus_ack outside BEAT0/BEAT1 is ignored. req_valid outside IDLE is not accepted (req_ready=0).
//  - Reset mid-beat abandons the access: no resp_valid; bus_req=0 after the reset edge; a late ack is ignored.
// TESTING
//  1. DATA_W=32: SW addr 0x10, wdata 0xDEADBEEF, ack at once -> bus_be=1111, addr 0x10; resp_valid at T+2, exc 00.
//  2. SB addr 0x13 data 0xA5 -> bus_be=1000, bus_wdata=0xA5000000.
//     Then LB addr 0x13 with rdata 0xA5000000 -> resp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
//  3. ALLOW_UNALIGNED=1: LW addr 0x0E.
//     Beat0 addr 0x0C, rdata 0xBBAA0000; beat1 addr 0x10, rdata 0x0000DDCC -> resp 0xDDCCBBAA at T+3.
//  4. ALLOW_UNALIGNED=0: LH 0x01 -> no bus_req, resp_exc=01 at T+1. SW 0x02 -> resp_exc=10.
//  5. Wait states: bus_ack low 3 cycles on an aligned LW.
//     bus_req/addr are stable throughout; resp_valid at T+5; req_valid held meanwhile is not accepted.
//  6. ADDR_W=32, SH at 0xFFFFFFFF, ALLOW_UNALIGNED=1 -> beat1 addr 0x00000000, be=0001.
//     Also: reset asserted during beat0 wait -> no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_align_ctrl.sv
// Load/store unit between the MEM stage and a req/ack data bus.
// Aligns stores, extracts/extends loads, and splits or rejects word-crossing accesses.
module lsu_align_ctrl #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned ALLOW_UNALIGNED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic [1:0]          resp_exc,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              cross_q;
  logic [1:0]        exc_q;
  logic [31:0]       lbuf_q;

  function automatic int unsigned op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b101:         return 4;
      3'b001, 3'b010, 3'b110: return 2;
      default:                return 1;
    endcase
  endfunction

  // Decode of the incoming request, used only on the accept edge.
  int unsigned in_size;
  int unsigned in_off;
  logic        in_cross;
  logic        in_mis;
  logic [1:0]  in_exc;

  always_comb begin
    in_size  = op_size(req_op);
    in_off   = 32'(req_addr[OFF_W-1:0]);
    in_cross = (in_off + in_size) > NB;
    if (in_size == 4)      in_mis = (req_addr[1:0] != 2'b00);
    else if (in_size == 2) in_mis = req_addr[0];
    else                   in_mis = 1'b0;
    in_exc = 2'b00;
    if (ALLOW_UNALIGNED == 0 && in_mis)
      in_exc = (req_op >= 3'b101) ? 2'b10 : 2'b01;
  end

  logic        beat;
  logic        second;
  logic        is_store;
  int unsigned cur_off;
  int unsigned cur_size;
  logic [31:0] gather;
  logic [ADDR_W-1:0] base_addr;

  assign beat      = (state == S_BEAT0) || (state == S_BEAT1);
  assign second    = (state == S_BEAT1);
  assign is_store  = (op_q >= 3'b101);
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Byte i of the access sits in lane off+i of beat 0, or lane off+i-NB of beat 1.
  always_comb begin
    cur_off   = 32'(addr_q[OFF_W-1:0]);
    cur_size  = op_size(op_q);
    gather    = '0;
    bus_be    = '0;
    bus_wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (beat && i < cur_size &&
            (second ? (cur_off + i >= NB && cur_off + i - NB == j)
                    : (cur_off + i < NB && cur_off + i == j))) begin
          gather[i*8 +: 8] = bus_rdata[j*8 +: 8];
          if (is_store) begin
            bus_be[j]          = 1'b1;
            bus_wdata[j*8 +: 8] = wdata_q[i*8 +: 8];
          end
        end
      end
    end
  end

  assign bus_req  = beat;
  assign bus_we   = beat && is_store;
  assign bus_addr = !beat ? '0 : (second ? base_addr + ADDR_W'(NB) : base_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      exc_q   <= '0;
      lbuf_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cross_q <= in_cross;
            exc_q   <= in_exc;
            lbuf_q  <= '0;
            state   <= (in_exc != 2'b00) ? S_RESP : S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (bus_ack) begin
            lbuf_q <= lbuf_q | gather;
            state  <= cross_q ? S_BEAT1 : S_RESP;
          end
        end
        S_BEAT1: begin
          if (bus_ack) begin
            lbuf_q <= lbuf_q | gather;
            state  <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [31:0] ext_data;

  always_comb begin
    case (op_q)
      3'b001:  ext_data = {{16{lbuf_q[15]}}, lbuf_q[15:0]};
      3'b010:  ext_data = {16'h0000, lbuf_q[15:0]};
      3'b011:  ext_data = {{24{lbuf_q[7]}}, lbuf_q[7:0]};
      3'b100:  ext_data = {24'h000000, lbuf_q[7:0]};
      default: ext_data = lbuf_q;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_exc   = resp_valid ? exc_q : 2'b00;
  assign resp_rdata = (resp_valid && !is_store && exc_q == 2'b00) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl: one unaligned-capable and one strict instance.
module tb_lsu_align_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        u_req_valid, u_req_ready, u_resp_valid, u_bus_req, u_bus_we, u_bus_ack;
  logic [2:0]  u_req_op;
  logic [31:0] u_req_addr, u_req_wdata, u_resp_rdata, u_bus_addr, u_bus_wdata, u_bus_rdata;
  logic [1:0]  u_resp_exc;
  logic [3:0]  u_bus_be;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_bus_req, a_bus_we, a_bus_ack;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [1:0]  a_resp_exc;
  logic [3:0]  a_bus_be;

  lsu_align_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(1)) dut_u (
    .clk(clk), .reset(reset),
    .req_valid(u_req_valid), .req_ready(u_req_ready), .req_op(u_req_op),
    .req_addr(u_req_addr), .req_wdata(u_req_wdata),
    .resp_valid(u_resp_valid), .resp_rdata(u_resp_rdata), .resp_exc(u_resp_exc),
    .bus_req(u_bus_req), .bus_we(u_bus_we), .bus_addr(u_bus_addr), .bus_be(u_bus_be),
    .bus_wdata(u_bus_wdata), .bus_ack(u_bus_ack), .bus_rdata(u_bus_rdata)
  );

  lsu_align_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(0)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_exc(a_resp_exc),
    .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be),
    .bus_wdata(a_bus_wdata), .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic u_issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    u_req_valid = 1'b1; u_req_op = op; u_req_addr = addr; u_req_wdata = wd;
    chk("u_ready_at_accept", u_req_ready, 1);
    tick();
    u_req_valid = 1'b0;
  endtask

  task automatic a_issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
    chk("a_ready_at_accept", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    u_req_valid = 0; u_req_op = 0; u_req_addr = 0; u_req_wdata = 0; u_bus_ack = 0; u_bus_rdata = 0;
    a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0; a_bus_ack = 0; a_bus_rdata = 0;
    @(negedge clk);
    // request and ack during reset must be ignored
    u_req_valid = 1'b1; u_bus_ack = 1'b1;
    tick(); tick();
    reset = 1'b0; u_req_valid = 1'b0; u_bus_ack = 1'b0;
    chk("rst_ready", u_req_ready, 1);
    chk("rst_bus_req", u_bus_req, 0);
    chk("rst_resp_valid", u_resp_valid, 0);
    chk("rst_bus_be", u_bus_be, 0);
    chk("rst_bus_addr", u_bus_addr, 0);
    chk("rst_rdata", u_resp_rdata, 0);
    tick();
    chk("idle_bus_req", u_bus_req, 0);

    // SW aligned, immediate ack
    u_issue(3'b101, 32'h10, 32'hDEADBEEF);
    chk("sw_req", u_bus_req, 1);
    chk("sw_we", u_bus_we, 1);
    chk("sw_addr", u_bus_addr, 32'h10);
    chk("sw_be", u_bus_be, 4'hF);
    chk("sw_wdata", u_bus_wdata, 32'hDEADBEEF);
    chk("sw_ready_busy", u_req_ready, 0);
    chk("sw_no_early_resp", u_resp_valid, 0);
    u_bus_ack = 1'b1;
    tick(); u_bus_ack = 1'b0;
    chk("sw_resp_valid", u_resp_valid, 1);
    chk("sw_resp_exc", u_resp_exc, 0);
    chk("sw_resp_rdata", u_resp_rdata, 0);
    chk("sw_req_dropped", u_bus_req, 0);
    tick();
    chk("sw_resp_pulse", u_resp_valid, 0);
    chk("sw_ready_back", u_req_ready, 1);

    // SB to lane 3; upper wdata bits must not leak
    u_issue(3'b111, 32'h13, 32'hFFFFFFA5);
    chk("sb_addr", u_bus_addr, 32'h10);
    chk("sb_be", u_bus_be, 4'h8);
    chk("sb_wdata", u_bus_wdata, 32'hA5000000);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("sb_resp", u_resp_valid, 1);
    tick();

    // LB / LBU from lane 3
    u_issue(3'b011, 32'h13, 0);
    chk("lb_we", u_bus_we, 0);
    chk("lb_be", u_bus_be, 0);
    chk("lb_addr", u_bus_addr, 32'h10);
    u_bus_rdata = 32'hA5000000; u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("lb_resp_valid", u_resp_valid, 1);
    chk("lb_rdata", u_resp_rdata, 32'hFFFFFFA5);
    tick();
    u_issue(3'b100, 32'h13, 0);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("lbu_rdata", u_resp_rdata, 32'h000000A5);
    tick();

    // SH / LH / LHU on upper halfword
    u_issue(3'b110, 32'h12, 32'hFFFF1234);
    chk("sh_be", u_bus_be, 4'hC);
    chk("sh_wdata", u_bus_wdata, 32'h12340000);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0; tick();
    u_issue(3'b001, 32'h12, 0);
    u_bus_rdata = 32'h80010000; u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("lh_rdata", u_resp_rdata, 32'hFFFF8001);
    tick();
    u_issue(3'b010, 32'h12, 0);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("lhu_rdata", u_resp_rdata, 32'h00008001);
    tick();

    // misaligned LH inside one word: single beat
    u_issue(3'b001, 32'h11, 0);
    chk("lh_mis_addr", u_bus_addr, 32'h10);
    u_bus_rdata = 32'h00BEEF00; u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("lh_mis_resp", u_resp_valid, 1);
    chk("lh_mis_rdata", u_resp_rdata, 32'hFFFFBEEF);
    chk("lh_mis_exc", u_resp_exc, 0);
    tick();

    // split LW at 0x0E
    u_issue(3'b000, 32'h0E, 0);
    chk("lw_split_b0_addr", u_bus_addr, 32'h0C);
    u_bus_rdata = 32'hBBAA0000; u_bus_ack = 1'b1; tick();
    chk("lw_split_b1_req", u_bus_req, 1);
    chk("lw_split_b1_addr", u_bus_addr, 32'h10);
    chk("lw_split_no_resp", u_resp_valid, 0);
    u_bus_rdata = 32'h0000DDCC; tick(); u_bus_ack = 1'b0;
    chk("lw_split_resp", u_resp_valid, 1);
    chk("lw_split_rdata", u_resp_rdata, 32'hDDCCBBAA);
    chk("lw_split_exc", u_resp_exc, 0);
    tick();

    // split SW at 0x0E
    u_issue(3'b101, 32'h0E, 32'h11223344);
    chk("sw_split_b0_be", u_bus_be, 4'hC);
    chk("sw_split_b0_wdata", u_bus_wdata, 32'h33440000);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("sw_split_b1_addr", u_bus_addr, 32'h10);
    chk("sw_split_b1_be", u_bus_be, 4'h3);
    chk("sw_split_b1_wdata", u_bus_wdata, 32'h00001122);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("sw_split_resp", u_resp_valid, 1);
    tick();

    // strict instance: exceptions with no bus beat
    a_issue(3'b001, 32'h01, 0);
    chk("a_lh_bus_req", a_bus_req, 0);
    chk("a_lh_resp", a_resp_valid, 1);
    chk("a_lh_exc", a_resp_exc, 2'b01);
    chk("a_lh_rdata", a_resp_rdata, 0);
    tick();
    chk("a_lh_ready", a_req_ready, 1);
    chk("a_lh_pulse", a_resp_valid, 0);
    a_issue(3'b101, 32'h02, 32'h12345678);
    chk("a_sw_bus_req", a_bus_req, 0);
    chk("a_sw_exc", a_resp_exc, 2'b10);
    tick();
    a_issue(3'b000, 32'h20, 0);
    chk("a_lw_req", a_bus_req, 1);
    chk("a_lw_addr", a_bus_addr, 32'h20);
    a_bus_rdata = 32'h12345678; a_bus_ack = 1'b1; tick(); a_bus_ack = 1'b0;
    chk("a_lw_rdata", a_resp_rdata, 32'h12345678);
    chk("a_lw_exc", a_resp_exc, 0);
    tick();

    // wait states with a competing request held high
    u_issue(3'b000, 32'h40, 0);
    u_req_valid = 1'b1; u_req_op = 3'b101; u_req_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      chk("ws_req", u_bus_req, 1);
      chk("ws_addr", u_bus_addr, 32'h40);
      chk("ws_ready", u_req_ready, 0);
      chk("ws_no_resp", u_resp_valid, 0);
      tick();
    end
    chk("ws_req_last", u_bus_req, 1);
    chk("ws_addr_last", u_bus_addr, 32'h40);
    u_bus_rdata = 32'hCAFEF00D; u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("ws_resp", u_resp_valid, 1);
    chk("ws_rdata", u_resp_rdata, 32'hCAFEF00D);
    u_req_valid = 1'b0;
    tick();
    chk("ws_not_accepted", u_bus_req, 0);
    chk("ws_ready_back", u_req_ready, 1);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("stray_ack_req", u_bus_req, 0);
    chk("stray_ack_resp", u_resp_valid, 0);

    // SH crossing the top of the address space
    u_issue(3'b110, 32'hFFFFFFFF, 32'h0000BEEF);
    chk("wrap_b0_addr", u_bus_addr, 32'hFFFFFFFC);
    chk("wrap_b0_be", u_bus_be, 4'h8);
    chk("wrap_b0_wdata", u_bus_wdata, 32'hEF000000);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("wrap_b1_addr", u_bus_addr, 32'h00000000);
    chk("wrap_b1_be", u_bus_be, 4'h1);
    chk("wrap_b1_wdata", u_bus_wdata, 32'h000000BE);
    u_bus_ack = 1'b1; tick(); u_bus_ack = 1'b0;
    chk("wrap_resp", u_resp_valid, 1);
    tick();

    // reset during beat0 wait abandons the access
    u_issue(3'b000, 32'h80, 0);
    chk("rmb_req", u_bus_req, 1);
    reset = 1'b1;
    tick();
    chk("rmb_req_cleared", u_bus_req, 0);
    chk("rmb_no_resp", u_resp_valid, 0);
    reset = 1'b0; u_bus_rdata = 32'h55555555; u_bus_ack = 1'b1;
    chk("rmb_ready", u_req_ready, 1);
    tick(); u_bus_ack = 1'b0;
    chk("rmb_late_ack_resp", u_resp_valid, 0);
    chk("rmb_late_ack_req", u_bus_req, 0);
    chk("rmb_ready_after", u_req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
